// File: rtl/capture_dump_controller.sv
// capture_dump_controller
// Runs one capture-and-dump cycle. It pulses the sampler start and waits for
// the sampler to finish. It then reads sample RAM from address 0 to LAST_ADDR
// and hands each byte to the UART transmitter.
// Optional build macro DUMP_HEADER_EN: when it is defined, the header bytes
// 8'hA5 and 8'h5A are sent ahead of the RAM contents.
// Debug: oDebugState exposes the current FSM state encoding.
//
// TX handshake: oTxStart is a one-cycle request that is issued only while
// iTxBusy is low. The transmitter answers by raising iTxBusy on the next
// cycle. oTxData stays frozen until iTxBusy falls again, and that fall marks
// the byte as consumed.
module capture_dump_controller #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR = 16'hFFFF
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic                  iTrigger,
  output logic                  oSampleStart,
  input  logic                  iSampleFinished,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  input  logic [DATA_WIDTH-1:0] iReadData,
  output logic [DATA_WIDTH-1:0] oTxData,
  output logic                  oTxStart,
  input  logic                  iTxBusy,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [3:0]            oDebugState
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ARM     = 4'd1,
    S_CAPTURE = 4'd2,
    S_READ    = 4'd3,
    S_LATCH   = 4'd4,
    S_SEND    = 4'd5,
    S_WAIT_HI = 4'd6,
    S_WAIT_LO = 4'd7,
    S_FINISH  = 4'd8,
    S_HDR0    = 4'd9,
    S_HDR1    = 4'd10
  } stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [ADDR_WIDTH-1:0] addrCounter;
  logic                  atLastAddr;
  logic                  dataPhase;

  assign atLastAddr = (addrCounter == LAST_ADDR);

`ifdef DUMP_HEADER_EN
  localparam logic [DATA_WIDTH-1:0] HDR_BYTE0 = DATA_WIDTH'(8'hA5);
  localparam logic [DATA_WIDTH-1:0] HDR_BYTE1 = DATA_WIDTH'(8'h5A);
  // 0: first header byte in flight, 1: second header byte, 2: RAM data
  logic [1:0] hdrPhase;
  assign dataPhase = (hdrPhase == 2'd2);
`else
  assign dataPhase = 1'b1;
`endif

  // State register; a reset drops back to IDLE at once, abandoning any transfer
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode and the single-cycle strobes
  always_comb begin
    stateNext    = state;
    oSampleStart = 1'b0;
    oTxStart     = 1'b0;
    oDone        = 1'b0;
    case (state)
      S_IDLE: begin
        if (iTrigger) stateNext = S_ARM;
      end
      S_ARM: begin
        oSampleStart = 1'b1;
        stateNext    = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (iSampleFinished) begin
`ifdef DUMP_HEADER_EN
          stateNext = S_HDR0;
`else
          stateNext = S_READ;
`endif
        end
      end
      S_READ:  stateNext = S_LATCH;
      S_LATCH: stateNext = S_SEND;
      S_SEND: begin
        if (!iTxBusy) begin
          oTxStart  = 1'b1;
          stateNext = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (iTxBusy) stateNext = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!iTxBusy) begin
`ifdef DUMP_HEADER_EN
          if (hdrPhase == 2'd0)      stateNext = S_HDR1;
          else if (hdrPhase == 2'd1) stateNext = S_READ;
          else if (atLastAddr)       stateNext = S_FINISH;
          else                       stateNext = S_READ;
`else
          stateNext = atLastAddr ? S_FINISH : S_READ;
`endif
        end
      end
      S_FINISH: begin
        oDone     = 1'b1;
        stateNext = S_IDLE;
      end
`ifdef DUMP_HEADER_EN
      S_HDR0: stateNext = S_SEND;
      S_HDR1: stateNext = S_SEND;
`endif
      default: stateNext = S_IDLE;
    endcase
  end

  // Address counter and TX data latch; the last-address test comes before the increment, so the counter never wraps
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      addrCounter <= '0;
      oTxData     <= '0;
`ifdef DUMP_HEADER_EN
      hdrPhase    <= 2'd0;
`endif
    end else begin
      if (state == S_CAPTURE && iSampleFinished) begin
        addrCounter <= '0;
`ifdef DUMP_HEADER_EN
        hdrPhase    <= 2'd0;
`endif
      end
      if (state == S_LATCH) oTxData <= iReadData;
      if (state == S_WAIT_LO && !iTxBusy && dataPhase && !atLastAddr) begin
        addrCounter <= addrCounter + 1'b1;
      end
`ifdef DUMP_HEADER_EN
      if (state == S_HDR0) oTxData <= HDR_BYTE0;
      if (state == S_HDR1) oTxData <= HDR_BYTE1;
      if (state == S_WAIT_LO && !iTxBusy && !dataPhase) hdrPhase <= hdrPhase + 2'd1;
`endif
    end
  end

  assign oBusy        = (state != S_IDLE);
  assign oReadAddress = addrCounter;
  assign oDebugState  = state;

endmodule

// File: tb/tb_capture_dump_controller.sv
// tb_capture_dump_controller
// Directed bench for capture_dump_controller with LAST_ADDR=3 (LAST_ADDR=1 when
// DUMP_HEADER_EN is defined). A RAM model with one-cycle registered read and a
// UART TX model that stays busy for 4 cycles surround the DUT.
module tb_capture_dump_controller;

`ifdef DUMP_HEADER_EN
  localparam logic [15:0] LAST = 16'd1;
  localparam int FIRST_START_DELAY = 2;
`else
  localparam logic [15:0] LAST = 16'd3;
  localparam int FIRST_START_DELAY = 3;
`endif
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_CAPTURE = 4'd2;
  localparam logic [3:0] ST_SEND    = 4'd5;

  logic        clk;
  logic        rstN;
  logic        trigger;
  logic        sampleStart;
  logic        sampleFinished;
  logic [15:0] readAddress;
  logic [7:0]  readData = '0;
  logic [7:0]  txData;
  logic        txStart;
  logic        txBusy;
  logic        busy;
  logic        done;
  logic [3:0]  debugState;
  logic        stallBusy;

  logic [7:0] ram [0:3];
  logic [7:0] expBytes [0:3];
  logic [7:0] exp_q[$];
  logic [7:0] gotQ[$];

  int total = 0;
  int bad = 0;

  capture_dump_controller #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LAST_ADDR(LAST)) dut (
    .iClock(clk),
    .iReset_n(rstN),
    .iTrigger(trigger),
    .oSampleStart(sampleStart),
    .iSampleFinished(sampleFinished),
    .oReadAddress(readAddress),
    .iReadData(readData),
    .oTxData(txData),
    .oTxStart(txStart),
    .iTxBusy(txBusy),
    .oBusy(busy),
    .oDone(done),
    .oDebugState(debugState)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // RAM model: registered read, one cycle of latency
  always @(posedge clk) readData <= ram[readAddress[1:0]];

  // UART TX model: busy for 4 cycles starting the cycle after a start
  int txCnt = 0;
  always @(posedge clk) begin
    if (txStart) txCnt <= 4;
    else if (txCnt != 0) txCnt <= txCnt - 1;
  end
  assign txBusy = (txCnt != 0) || stallBusy;

  // monitor samples mid low phase, after the bench's drive point
  int sampleStartCount = 0;
  int txStartCount = 0;
  int doneCount = 0;
  int dataChanges = 0;
  int cycle = 0;
  int lastBusyFall = 0;
  int doneCycle = 0;
  logic prevBusy = 1'b0;
  logic holding = 1'b0;
  logic sawBusy = 1'b0;
  logic [7:0] heldData = '0;
  always begin
    @(negedge clk);
    #3;
    cycle++;
    if (sampleStart) sampleStartCount++;
    if (done) begin
      doneCount++;
      doneCycle = cycle;
    end
    if (prevBusy && !txBusy) lastBusyFall = cycle;
    prevBusy = txBusy;
    if (holding) begin
      if (txData !== heldData) dataChanges++;
      if (txBusy) sawBusy = 1'b1;
      else if (sawBusy) holding = 1'b0;
    end
    if (txStart) begin
      gotQ.push_back(txData);
      txStartCount++;
      heldData = txData;
      holding  = 1'b1;
      sawBusy  = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulseTrigger();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic pulseFinished();
    sampleFinished = 1'b1;
    tick(1);
    sampleFinished = 1'b0;
  endtask

  task automatic loadExp();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(expBytes[i]);
  endtask

  task automatic waitDone(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic scoreboard(input string tag, input int base);
    logic [7:0] e;
    logic [7:0] g;
    int idx;
    check($sformatf("%s_count", tag), gotQ.size() - base, exp_q.size());
    idx = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (idx < gotQ.size()) ? gotQ[idx] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, idx - base), g, e);
      idx++;
    end
  endtask

  initial begin
    int base;
    int doneBase;
    int startBase;
    int sampleBase;
    bit stallOk;
    bit ok;

`ifdef DUMP_HEADER_EN
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h00; ram[3] = 8'h00;
    expBytes[0] = 8'hA5; expBytes[1] = 8'h5A; expBytes[2] = 8'h01; expBytes[3] = 8'h02;
`else
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    expBytes[0] = 8'h11; expBytes[1] = 8'h22; expBytes[2] = 8'h33; expBytes[3] = 8'h44;
`endif
    rstN = 1'b0;
    trigger = 1'b0;
    sampleFinished = 1'b0;
    stallBusy = 1'b0;

    // reset state
    tick(3);
    check("rst_sample_start", sampleStart, 1'b0);
    check("rst_tx_start", txStart, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_read_addr", readAddress, 16'h0);
    check("rst_tx_data", txData, 8'h00);
    check("rst_state", debugState, ST_IDLE);
    rstN = 1'b1;
    tick(2);

    // run 1: full dump with ignored inputs
    base = gotQ.size();
    doneBase = doneCount;
    sampleBase = sampleStartCount;
    loadExp();
    pulseTrigger();
    check("arm_pulse", sampleStart, 1'b1);
    tick(1);
    check("arm_one_cycle", sampleStart, 1'b0);
    check("capture_state", debugState, ST_CAPTURE);
    pulseTrigger();
    tick(2);
    check("trig_ignored_state", debugState, ST_CAPTURE);
    check("trig_ignored_count", sampleStartCount - sampleBase, 1);
    pulseFinished();
    check("first_read_addr", readAddress, 16'h0);
    for (int i = 1; i < FIRST_START_DELAY; i++) begin
      check("no_early_start", txStart, 1'b0);
      tick(1);
    end
    check("first_start_latency", txStart, 1'b1);
    tick(2);
    pulseTrigger();
    waitDone("run1_done_seen");
    tick(1);
    check("run1_done_latency", doneCycle, lastBusyFall + 1);
    check("run1_done_count", doneCount - doneBase, 1);
    check("run1_idle_busy", busy, 1'b0);
    check("run1_sample_starts", sampleStartCount - sampleBase, 1);
    check("run1_data_stable", dataChanges, 0);
    scoreboard("run1", base);

    // finish pulse in IDLE is ignored
    pulseFinished();
    tick(2);
    check("fin_idle_state", debugState, ST_IDLE);
    check("fin_idle_busy", busy, 1'b0);
    check("fin_idle_sample_starts", sampleStartCount - sampleBase, 1);

    // run 2: TX busy stall before the first send
    base = gotQ.size();
    doneBase = doneCount;
    startBase = txStartCount;
    loadExp();
    stallBusy = 1'b1;
    pulseTrigger();
    tick(1);
    pulseFinished();
    stallOk = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (txStart !== 1'b0) stallOk = 1'b0;
      tick(1);
    end
    check("stall_no_start", stallOk, 1'b1);
    check("stall_state", debugState, ST_SEND);
    check("stall_tx_data", txData, expBytes[0]);
    check("stall_start_count", txStartCount - startBase, 0);
    stallBusy = 1'b0;
    #1;
    check("stall_release_start", txStart, 1'b1);
    waitDone("run2_done_seen");
    tick(1);
    check("run2_done_count", doneCount - doneBase, 1);
    check("run2_data_stable", dataChanges, 0);
    scoreboard("run2", base);

    // run 3: abort after the second byte request, then a clean restart
    startBase = txStartCount;
    pulseTrigger();
    tick(1);
    pulseFinished();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (txStartCount - startBase >= 2) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("abort_second_start_seen", ok, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_state", debugState, ST_IDLE);
    check("abort_tx_start", txStart, 1'b0);
    check("abort_tx_data", txData, 8'h00);
    check("abort_read_addr", readAddress, 16'h0);
    tick(2);
    rstN = 1'b1;
    tick(8);

    base = gotQ.size();
    doneBase = doneCount;
    loadExp();
    pulseTrigger();
    check("restart_arm_pulse", sampleStart, 1'b1);
    tick(1);
    pulseFinished();
    check("restart_read_addr", readAddress, 16'h0);
    waitDone("run3_done_seen");
    tick(1);
    check("run3_done_count", doneCount - doneBase, 1);
    check("run3_idle_busy", busy, 1'b0);
    scoreboard("run3", base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_dump_controller.md
Name: capture_dump_controller

Overview:
- Sequences one capture-and-dump cycle on the RS232 test bench: pulses the sampler start, waits for sampling to finish, then reads sample RAM from address 0 to LAST_ADDR and sends each byte to the UART transmitter.
- Sits between the trigger source, the sampler, the sample RAM read port and the UART TX.
- The sampler owns the RAM write port during capture; this block owns the read port during dump.

Parameters:
- ADDR_WIDTH, 16, width of the sample RAM address.
- DATA_WIDTH, 8, width of the sample word and the UART byte.
- LAST_ADDR, 16'hFFFF, final RAM address dumped (inclusive).

Ports:
- iClock  in  1  system clock; all logic is on its rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iTrigger  in  1  level; when sampled high in IDLE, starts one cycle.
- oSampleStart  out  1  one-cycle pulse to the sampler start input.
- iSampleFinished  in  1  one-cycle pulse from the sampler when capture completes.
- oReadAddress  out  ADDR_WIDTH  sample RAM read address; RAM has 1-cycle registered read latency.
- iReadData  in  DATA_WIDTH  sample RAM read data.
- oTxData  out  DATA_WIDTH  byte to the UART TX; held stable from oTxStart until iTxBusy falls.
- oTxStart  out  1  one-cycle pulse requesting transmission of oTxData.
- iTxBusy  in  1  high while the UART shifts a byte; rises the cycle after oTxStart.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse after the last byte has finished sending.

Behaviour:
- Reset (async, iReset_n=0):
  - state=IDLE.
  - All outputs 0; oReadAddress=0, oTxData=0.
  - Internal address counter=0.
  - A reset mid-operation aborts immediately; no partial handshake is completed.
- States and transitions:
  - IDLE: when iTrigger=1, go to ARM.
  - ARM: oSampleStart=1 for exactly one cycle; go to CAPTURE.
  - CAPTURE: wait for iSampleFinished=1; then clear the address counter to 0 and go to READ. There is no timeout.
  - READ: drive oReadAddress=counter; go to LATCH.
  - LATCH: register iReadData into oTxData (data valid now, per the 1-cycle latency); go to SEND.
  - SEND: wait until iTxBusy=0, then assert oTxStart for one cycle; go to WAIT_HI.
  - WAIT_HI: wait for iTxBusy=1; go to WAIT_LO.
  - WAIT_LO: wait for iTxBusy=0. If counter==LAST_ADDR, go to FINISH; otherwise counter+1 and go to READ.
  - FINISH: oDone=1 for one cycle; go to IDLE.
- Latency:
  - iTrigger sampled high to oSampleStart: 1 cycle.
  - iSampleFinished to first oTxStart: 3 cycles when iTxBusy=0.
- Counter:
  - ADDR_WIDTH bits, never wraps.
  - The comparison with LAST_ADDR is done before incrementing, so LAST_ADDR=2^ADDR_WIDTH-1 ends the cycle without overflow.
  - Exactly LAST_ADDR+1 bytes are sent per cycle.
- Ignored inputs:
  - iTrigger is ignored in every state except IDLE.
  - A trigger held high through FINISH starts a new cycle on the first IDLE cycle.
  - iSampleFinished is ignored outside CAPTURE.
  - iTxBusy is ignored in READ and LATCH.
- Simultaneous events:
  - iSampleFinished arriving in the same cycle the state enters CAPTURE (ARM→CAPTURE edge) is not seen; the sampler cannot finish that quickly.
  - A pulse during CAPTURE is always caught.
- oTxData changes only in LATCH.

Optional Feature:
- Macro: DUMP_HEADER_EN.
- Defined:
  - After CAPTURE and before the first READ, send header bytes 8'hA5 then 8'h5A using the same SEND/WAIT_HI/WAIT_LO handshake (extra states HDR0, HDR1).
  - Total bytes per cycle = LAST_ADDR+3.
- Undefined: no header states; the dump begins directly at address 0.

Test Plan:
- Reset: LAST_ADDR=3, hold iReset_n=0 → all outputs 0. Release, pulse iTrigger → oSampleStart high exactly 1 cycle, 1 cycle after the trigger.
- Full dump: RAM model holds {0x11,0x22,0x33,0x44}, pulse iSampleFinished, TX model with busy=4 cycles → oTxStart pulses 4 times with oTxData 0x11,0x22,0x33,0x44 in order. oDone pulses once, 1 cycle after the last busy fall; oBusy=0 afterwards.
- Ignored inputs: pulse iTrigger during CAPTURE and during the dump, pulse iSampleFinished in IDLE → no extra oSampleStart, no state change, byte sequence unchanged.
- Busy stall: iTxBusy held high for 50 cycles before the first SEND → oTxStart withheld until iTxBusy=0, then exactly one pulse; oTxData stable throughout.
- Abort: assert iReset_n=0 after the second oTxStart → outputs 0 asynchronously. A new trigger restarts from ARM, and the dump restarts at address 0.
- DUMP_HEADER_EN defined, LAST_ADDR=1, RAM {0x01,0x02} → bytes sent are 0xA5,0x5A,0x01,0x02, followed by a single oDone.
